// File: rtl/demultiplexer2.sv
// One-entry buffered 1-to-3 demultiplexer with valid/ready handshakes on both sides.
// Optional illegal-select drop counter enabled by defining DEMUX2_ERRCNT_EN.
module demultiplexer2 #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    input  logic [1:0]       s,
    output logic [Width-1:0] output0,
    output logic [Width-1:0] output1,
    output logic [Width-1:0] output2,
    output logic [2:0]       out_valid,
    input  logic [2:0]       out_ready,
    output logic [7:0]       err_cnt
);

    localparam int unsigned NumDest = 3;
    localparam logic [1:0]  IllegalSel = 2'd3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state;
    logic               xfer_in;
    logic               xfer_out;
    logic               load;
    logic [NumDest-1:0] load_sel;

    // The one-hot out_valid register doubles as the buffered destination.
    always_comb begin
        xfer_out = (state == FULL) && (|(out_ready & out_valid));
        in_ready = (state == EMPTY) || (|(out_ready & out_valid));
        xfer_in  = in_valid && in_ready;
        load     = xfer_in && (s != IllegalSel);
        load_sel = NumDest'(3'b001 << s);
    end

    // Buffer: a new word overrides a simultaneous drain so throughput stays at one word per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= '0;
            output0   <= '0;
            output1   <= '0;
            output2   <= '0;
        end else if (load) begin
            state     <= FULL;
            out_valid <= load_sel;
            output0   <= load_sel[0] ? in_data : '0;
            output1   <= load_sel[1] ? in_data : '0;
            output2   <= load_sel[2] ? in_data : '0;
        end else if (xfer_out) begin
            state     <= EMPTY;
            out_valid <= '0;
            output0   <= '0;
            output1   <= '0;
            output2   <= '0;
        end
    end

`ifdef DEMUX2_ERRCNT_EN
    logic drop;

    assign drop = xfer_in && (s == IllegalSel);

    // Saturating count of words dropped for an illegal select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (drop && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_demultiplexer2.sv
// Directed bench for demultiplexer2 with a queue of expected deliveries.
module tb_demultiplexer2;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   s;
    logic [W-1:0] output0;
    logic [W-1:0] output1;
    logic [W-1:0] output2;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready;
    logic [7:0]   err_cnt;

    typedef struct {
        logic [1:0]   dest;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    demultiplexer2 #(.Width(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .s         (s),
        .output0   (output0),
        .output1   (output1),
        .output2   (output2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare the presented word against the queue head; pop when it drains this cycle.
    task automatic chk_word(input string tag, input bit pop);
        exp_t e;
        logic [2:0] ev;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_queue expected=pending_word", tag);
        end else begin
            e  = sb[0];
            ev = 3'b001 << e.dest;
            chk({tag, "_valid"}, W'(out_valid), W'(ev));
            chk({tag, "_out0"}, output0, (e.dest == 2'd0) ? e.data : '0);
            chk({tag, "_out1"}, output1, (e.dest == 2'd1) ? e.data : '0);
            chk({tag, "_out2"}, output2, (e.dest == 2'd2) ? e.data : '0);
            if (pop) void'(sb.pop_front());
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, W'(out_valid), W'(3'b000));
        chk({tag, "_out0"}, output0, '0);
        chk({tag, "_out1"}, output1, '0);
        chk({tag, "_out2"}, output2, '0);
    endtask

    task automatic push(input logic [1:0] d, input logic [W-1:0] v);
        exp_t e;
        e.dest = d;
        e.data = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_one;
        logic [7:0] exp_sat;
`ifdef DEMUX2_ERRCNT_EN
        exp_one = 8'd1;
        exp_sat = 8'd255;
`else
        exp_one = 8'd0;
        exp_sat = 8'd0;
`endif
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        s         = 2'd0;
        out_ready = 3'b000;
        #1;
        chk_idle("rst");
        chk("rst_in_ready", W'(in_ready), W'(1'b1));
        chk("rst_err_cnt", W'(err_cnt), W'(8'd0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", W'(in_ready), W'(1'b1));

        // Single word to destination 0, held while out_ready is low.
        in_valid = 1'b1;
        in_data  = 32'h1;
        s        = 2'd0;
        push(2'd0, 32'h1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_word("hold0", 1'b0);
            chk("hold0_in_ready", W'(in_ready), W'(1'b0));
            tick();
        end
        out_ready = 3'b110;
        #1;
        chk("nonsel_in_ready", W'(in_ready), W'(1'b0));
        tick();
        chk_word("nonsel_hold", 1'b0);
        out_ready = 3'b001;
        #1;
        chk("drain0_in_ready", W'(in_ready), W'(1'b1));
        chk_word("drain0", 1'b1);
        tick();
        out_ready = 3'b000;
        chk_idle("after_drain0");

        // Back-to-back words with all destinations ready.
        out_ready = 3'b111;
        in_valid  = 1'b1;
        in_data   = 32'hAAAA_0001;
        s         = 2'd1;
        push(2'd1, 32'hAAAA_0001);
        #1;
        chk("b2b_in_ready_a", W'(in_ready), W'(1'b1));
        tick();
        in_data = 32'hBBBB_0002;
        s       = 2'd2;
        push(2'd2, 32'hBBBB_0002);
        #1;
        chk_word("b2b_a", 1'b1);
        chk("b2b_in_ready_b", W'(in_ready), W'(1'b1));
        tick();
        in_data = 32'hCCCC_0003;
        s       = 2'd0;
        push(2'd0, 32'hCCCC_0003);
        #1;
        chk_word("b2b_b", 1'b1);
        chk("b2b_in_ready_c", W'(in_ready), W'(1'b1));
        tick();
        in_valid = 1'b0;
        chk_word("b2b_c", 1'b1);
        chk("b2b_in_ready_end", W'(in_ready), W'(1'b1));
        tick();
        chk_idle("b2b_idle");

        // Destination 2 stalls until its own ready bit rises.
        out_ready = 3'b011;
        in_valid  = 1'b1;
        in_data   = 32'hDDDD_0004;
        s         = 2'd2;
        push(2'd2, 32'hDDDD_0004);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk_word("stall2", 1'b0);
            chk("stall2_in_ready", W'(in_ready), W'(1'b0));
            tick();
        end
        out_ready = 3'b100;
        #1;
        chk("drain2_in_ready", W'(in_ready), W'(1'b1));
        chk_word("drain2", 1'b1);
        tick();
        out_ready = 3'b000;
        chk_idle("after_drain2");

        // Illegal select words are dropped and counted.
        in_valid = 1'b1;
        s        = 2'd3;
        for (int i = 0; i < 300; i++) begin
            in_data = W'(i + 32'h100);
            tick();
            chk("illegal_valid", W'(out_valid), W'(3'b000));
            if (i == 0) chk("err_cnt_first", W'(err_cnt), W'(exp_one));
        end
        in_valid = 1'b0;
        chk("err_cnt_sat", W'(err_cnt), W'(exp_sat));
        chk_idle("illegal_idle");

        // Asynchronous reset discards a buffered word.
        in_valid = 1'b1;
        in_data  = 32'hEEEE_0005;
        s        = 2'd1;
        push(2'd1, 32'hEEEE_0005);
        tick();
        in_valid = 1'b0;
        chk_word("pre_rst", 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_in_ready", W'(in_ready), W'(1'b1));
        chk("async_rst_err_cnt", W'(err_cnt), W'(8'd0));
        sb.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_redeliver_valid", W'(out_valid), W'(3'b000));
            chk("no_redeliver_out1", output1, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
